fetch_ctrl: RTL and testbench

Instruction-fetch controller for the pipelined MIPS core. It owns the PC register and drives the 30-bit word address consumed by the next-PC logic. It takes the computed next PC back, issues one instruction-memory request at a time over a valid/ready handshake, and hands fetched words to decode through a one-entry output buffer. On a redirect it squashes in-flight responses.

---
 rtl/fetch_ctrl_pkg.sv | 12 +
 rtl/fetch_buf.sv | 51 +++++
 rtl/fetch_ctrl.sv | 97 +++++++++
 tb/tb_fetch_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller and the core top.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  localparam logic [29:0] RESET_PC_DEFAULT = 30'h0000_0C00;

endpackage

// File: rtl/fetch_buf.sv
// One-entry holding register between instruction memory and decode.
module fetch_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        drain,
  input  logic        flush,
  input  logic [31:0] load_instr,
  input  logic [29:0] load_pc,
  output logic        valid,
  output logic [31:0] instr,
  output logic [29:0] pc
);

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [29:0] pc_q, pc_d;

  // Flush beats load, and a reload in the same cycle as a drain keeps the entry.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = load_instr;
      pc_d    = load_pc;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid = valid_q;
  assign instr = instr_q;
  assign pc    = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, issues one memory request at a
// time and squashes responses that belong to a redirected stream.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [29:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:2] PC,
  input  logic [31:2] NPC,
  input  logic        redirect,
  input  logic        stall,
  output logic        imem_req_valid,
  output logic [31:2] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:2] if_pc,
  input  logic        if_ready
);

  fetch_state_e state_q, state_d;
  logic [29:0]  pc_q, pc_d;
  logic [29:0]  req_pc_q, req_pc_d;
  logic         issue;
  logic         accept;
  logic         buf_load;

  // Only issue when the buffer will have room for the response.
  assign issue  = !rst && (state_q == REQ) && !stall && !redirect
                  && (!if_valid || if_ready);
  assign accept = issue && imem_req_ready;

  assign imem_req_valid = issue;
  assign imem_req_addr  = pc_q;
  assign PC             = pc_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    buf_load = 1'b0;
    if (redirect) begin
      pc_d = NPC;
    end else if (accept) begin
      pc_d     = NPC;
      req_pc_d = pc_q;
    end
    unique case (state_q)
      REQ: begin
        if (accept) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          buf_load = !redirect;
          state_d  = REQ;
        end else if (redirect) begin
          state_d = DROP;
        end
      end
      DROP: begin
        // The squashed response is still owed; a redirect here only moves the PC.
        if (imem_rsp_valid) state_d = REQ;
      end
      default: state_d = REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  fetch_buf u_fetch_buf (
    .clk        (clk),
    .rst        (rst),
    .load       (buf_load),
    .drain      (if_ready),
    .flush      (redirect),
    .load_instr (imem_rsp_data),
    .load_pc    (req_pc_q),
    .valid      (if_valid),
    .instr      (if_instr),
    .pc         (if_pc)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed, table-driven bench for fetch_ctrl with hand-computed expectations.
module tb_fetch_ctrl;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [29:0] npc;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        if_ready;
    logic        chk;
    logic        exp_req_valid;
    logic [29:0] exp_pc;
    logic        exp_if_valid;
    logic        chk_data;
    logic [29:0] exp_if_pc;
    logic [31:0] exp_if_instr;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [31:2] pc;
  logic [31:2] npc;
  logic        redirect;
  logic        stall;
  logic        imem_req_valid;
  logic [31:2] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:2] if_pc;
  logic        if_ready;

  int assertCount = 0;
  int failCount   = 0;

  vec_t vecs [29];

  fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .PC             (pc),
    .NPC            (npc),
    .redirect       (redirect),
    .stall          (stall),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_ready       (if_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic s, input logic rd,
                              input logic [29:0] n, input logic qr,
                              input logic rv, input logic [31:0] data,
                              input logic ir, input logic c, input logic erv,
                              input logic [29:0] epc, input logic eiv,
                              input logic cd, input logic [29:0] eipc,
                              input logic [31:0] eins);
    vec_t v;
    v.rst = r;           v.stall = s;          v.redirect = rd;
    v.npc = n;           v.req_ready = qr;     v.rsp_valid = rv;
    v.rsp_data = data;   v.if_ready = ir;      v.chk = c;
    v.exp_req_valid = erv; v.exp_pc = epc;     v.exp_if_valid = eiv;
    v.chk_data = cd;     v.exp_if_pc = eipc;   v.exp_if_instr = eins;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    @(negedge clk);
    rst            = v.rst;
    stall          = v.stall;
    redirect       = v.redirect;
    npc            = v.npc;
    imem_req_ready = v.req_ready;
    imem_rsp_valid = v.rsp_valid;
    imem_rsp_data  = v.rsp_data;
    if_ready       = v.if_ready;
    #1;
    if (v.chk) begin
      checkOutput({tag, " req_valid"}, 32'(imem_req_valid), 32'(v.exp_req_valid));
      checkOutput({tag, " req_addr"},  32'(imem_req_addr),  32'(v.exp_pc));
      checkOutput({tag, " pc"},        32'(pc),             32'(v.exp_pc));
      checkOutput({tag, " if_valid"},  32'(if_valid),       32'(v.exp_if_valid));
      if (v.chk_data) begin
        checkOutput({tag, " if_pc"},    32'(if_pc),   32'(v.exp_if_pc));
        checkOutput({tag, " if_instr"}, if_instr,     v.exp_if_instr);
      end
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; npc = 30'hC01;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    if_ready = 1'b0;

    // reset, free run with zero-wait memory
    vecs[0]  = mk(1,0,0,30'hC01,1,0,32'h0,1,         0,0,30'h000,0,0,30'h000,32'h0);
    vecs[1]  = mk(1,0,0,30'hC01,1,0,32'h0,1,         1,0,30'hC00,0,1,30'h000,32'h0);
    vecs[2]  = mk(0,0,0,30'hC01,1,0,32'h0,1,         1,1,30'hC00,0,0,30'h000,32'h0);
    vecs[3]  = mk(0,0,0,30'hC02,1,1,32'hD0000C00,1,  1,0,30'hC01,0,0,30'h000,32'h0);
    vecs[4]  = mk(0,0,0,30'hC02,1,0,32'h0,1,         1,1,30'hC01,1,1,30'hC00,32'hD0000C00);
    vecs[5]  = mk(0,0,0,30'hC03,1,1,32'hD0000C01,1,  1,0,30'hC02,0,0,30'h000,32'h0);
    vecs[6]  = mk(0,0,0,30'hC03,1,0,32'h0,1,         1,1,30'hC02,1,1,30'hC01,32'hD0000C01);
    vecs[7]  = mk(0,0,0,30'hC04,1,1,32'hD0000C02,1,  1,0,30'hC03,0,0,30'h000,32'h0);
    vecs[8]  = mk(0,0,0,30'hC04,1,0,32'h0,1,         1,1,30'hC03,1,1,30'hC02,32'hD0000C02);
    // backpressure from decode
    vecs[9]  = mk(0,0,0,30'hC05,1,1,32'hD0000C03,0,  1,0,30'hC04,0,0,30'h000,32'h0);
    vecs[10] = mk(0,0,0,30'hC05,1,0,32'h0,0,         1,0,30'hC04,1,1,30'hC03,32'hD0000C03);
    vecs[11] = mk(0,0,0,30'hC05,1,0,32'h0,0,         1,0,30'hC04,1,1,30'hC03,32'hD0000C03);
    vecs[12] = mk(0,0,0,30'hC05,1,0,32'h0,1,         1,1,30'hC04,1,1,30'hC03,32'hD0000C03);
    // redirect while a request is outstanding
    vecs[13] = mk(0,0,1,30'h123,1,0,32'h0,1,         1,0,30'hC05,0,0,30'h000,32'h0);
    vecs[14] = mk(0,0,0,30'h124,1,1,32'hD0000C04,1,  1,0,30'h123,0,0,30'h000,32'h0);
    vecs[15] = mk(0,0,0,30'h124,1,0,32'h0,1,         1,1,30'h123,0,0,30'h000,32'h0);
    vecs[16] = mk(0,0,0,30'h125,1,1,32'hD0000123,1,  1,0,30'h124,0,0,30'h000,32'h0);
    vecs[17] = mk(0,0,0,30'h125,0,0,32'h0,1,         1,1,30'h124,1,1,30'h123,32'hD0000123);
    // redirect coincident with the response
    vecs[18] = mk(0,0,1,30'hC04,0,0,32'h0,1,         1,0,30'h124,0,0,30'h000,32'h0);
    vecs[19] = mk(0,0,0,30'hC05,1,0,32'h0,1,         1,1,30'hC04,0,0,30'h000,32'h0);
    vecs[20] = mk(0,0,1,30'h200,1,1,32'hD0000C04,1,  1,0,30'hC05,0,0,30'h000,32'h0);
    vecs[21] = mk(0,0,0,30'h201,1,0,32'h0,1,         1,1,30'h200,0,0,30'h000,32'h0);
    vecs[22] = mk(0,0,0,30'h202,1,1,32'hD0000200,1,  1,0,30'h201,0,0,30'h000,32'h0);
    // stall: PC holds, drain and outstanding response still proceed
    vecs[23] = mk(0,1,0,30'h201,1,0,32'h0,1,         1,0,30'h201,1,1,30'h200,32'hD0000200);
    vecs[24] = mk(0,1,0,30'h201,1,0,32'h0,1,         1,0,30'h201,0,0,30'h000,32'h0);
    vecs[25] = mk(0,1,0,30'h201,1,0,32'h0,1,         1,0,30'h201,0,0,30'h000,32'h0);
    vecs[26] = mk(0,0,0,30'h202,1,0,32'h0,1,         1,1,30'h201,0,0,30'h000,32'h0);
    vecs[27] = mk(0,1,0,30'h202,1,1,32'hD0000201,1,  1,0,30'h202,0,0,30'h000,32'h0);
    vecs[28] = mk(0,1,0,30'h202,1,0,32'h0,0,         1,0,30'h202,1,1,30'h201,32'hD0000201);

    for (int i = 0; i < 29; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // memory holds off ready for four cycles; request must stay put
    for (int i = 0; i < 4; i++) begin
      applyStimulus(mk(0,0,0,30'h203,0,0,32'h0,1, 1,1,30'h202,(i == 0),(i == 0),
                       30'h201,32'hD0000201), $sformatf("rdydly%0d", i));
    end
    applyStimulus(mk(0,0,0,30'h203,1,0,32'h0,1, 1,1,30'h202,0,0,30'h000,32'h0), "rdyacc");
    applyStimulus(mk(0,0,0,30'h204,1,0,32'h0,1, 1,0,30'h203,0,0,30'h000,32'h0), "rdyonce");
    applyStimulus(mk(0,0,0,30'h204,1,1,32'hD0000202,1, 1,0,30'h203,0,0,30'h000,32'h0), "rdyrsp");
    applyStimulus(mk(0,0,0,30'h204,1,0,32'h0,0, 1,0,30'h203,1,1,30'h202,32'hD0000202), "rdybuf");

    // reset while a request is outstanding
    applyStimulus(mk(0,0,0,30'h204,1,0,32'h0,1, 1,1,30'h203,1,1,30'h202,32'hD0000202), "rstiss");
    applyStimulus(mk(1,0,0,30'h204,1,0,32'h0,1, 1,0,30'h204,0,0,30'h000,32'h0), "rstcyc");
    applyStimulus(mk(0,0,0,30'hC01,0,0,32'h0,1, 1,1,30'hC00,0,1,30'h000,32'h0), "rstpost");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
